// File: rtl/nibble_serial_sub.sv
// Serial WIDTH-bit subtractor: one 4-bit lookahead-borrow slice per clock, LSB slice first,
// behind valid/ready handshakes. APPROX=1 drops the inter-slice borrow for error studies.
module nibble_serial_sub #(
  parameter int WIDTH  = 16,
  parameter bit APPROX = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic             r_borrow_out;

  logic [3:0]       w_a_slices [NSLICE];
  logic [3:0]       w_b_slices [NSLICE];
  logic [3:0]       w_sa;
  logic [3:0]       w_sb;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [3:0]       w_sd;
  logic [4:0]       w_c;
  logic             w_bin;
  logic             w_accept;
  logic             w_run;
  logic             w_last;

  // Slice views of the latched operands, selected by the slice counter.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
    assign w_a_slices[gi] = r_a[4*gi +: 4];
    assign w_b_slices[gi] = r_b[4*gi +: 4];
  end

  assign w_sa  = w_a_slices[r_cnt];
  assign w_sb  = w_b_slices[r_cnt];
  assign w_bin = (APPROX == 1'b0) ? r_bin : 1'b0;

  // Borrow generate when a_i=0,b_i=1; an incoming borrow passes through when a_i==b_i.
  assign w_c[0] = w_bin;
  for (genvar gi = 0; gi < 4; gi++) begin : g_borrow
    assign w_g[gi]    = ~w_sa[gi] & w_sb[gi];
    assign w_p[gi]    = ~(w_sa[gi] ^ w_sb[gi]);
    assign w_c[gi+1]  = w_g[gi] | (w_p[gi] & w_c[gi]);
    assign w_sd[gi]   = w_sa[gi] ^ w_sb[gi] ^ w_c[gi];
  end

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_cnt == LAST_SLICE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_diff       <= '0;
      r_cnt        <= '0;
      r_bin        <= 1'b0;
      r_borrow_out <= 1'b0;
    end else if (w_accept) begin
      r_a          <= a;
      r_b          <= b;
      r_diff       <= '0;
      r_cnt        <= '0;
      r_bin        <= 1'b0;
      r_borrow_out <= 1'b0;
    end else if (w_run) begin
      for (int k = 0; k < NSLICE; k++) begin
        if (r_cnt == CW'(k)) r_diff[4*k +: 4] <= w_sd;
      end
      r_bin <= w_c[4];
      if (w_last) begin
        r_borrow_out <= w_c[4];
        r_cnt        <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Bench for nibble_serial_sub: exact and approximate instances run in lockstep against
// arithmetic reference models (full-width subtract and independent per-nibble subtract).
module tb_nibble_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        in_ready, out_valid, borrow_out, busy;
  logic [15:0] diff;
  logic        x_in_ready, x_out_valid, x_borrow_out, x_busy;
  logic [15:0] x_diff;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] dir_a  [3] = '{16'h1234, 16'h0000, 16'h1000};
  logic [15:0] dir_b  [3] = '{16'h0234, 16'h0001, 16'h0001};
  logic [16:0] dir_ex [3] = '{{1'b0, 16'h1000}, {1'b1, 16'hFFFF}, {1'b0, 16'h0FFF}};
  logic [16:0] dir_ax [3] = '{{1'b0, 16'h1000}, {1'b0, 16'h000F}, {1'b0, 16'h100F}};

  always #5 clk = ~clk;

  nibble_serial_sub #(.WIDTH(16), .APPROX(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .busy(busy)
  );

  nibble_serial_sub #(.WIDTH(16), .APPROX(1'b1)) dut_ax (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x_in_ready),
    .a(a), .b(b), .out_valid(x_out_valid), .out_ready(out_ready),
    .diff(x_diff), .borrow_out(x_borrow_out), .busy(x_busy)
  );

  // {borrow, difference} of a full 16-bit subtraction.
  function automatic logic [16:0] model_exact(input logic [15:0] ta, input logic [15:0] tb_);
    logic [15:0] d;
    d = ta - tb_;
    return {(ta < tb_), d};
  endfunction

  // Each nibble subtracted on its own mod 16; borrow is the top nibble's own borrow.
  function automatic logic [16:0] model_approx(input logic [15:0] ta, input logic [15:0] tb_);
    logic [15:0] d;
    logic [3:0]  an, bn;
    for (int k = 0; k < 4; k++) begin
      an = ta[4*k +: 4];
      bn = tb_[4*k +: 4];
      d[4*k +: 4] = an - bn;
    end
    return {(ta[15:12] < tb_[15:12]), d};
  endfunction

  task automatic issue_op(input logic [15:0] ta, input logic [15:0] tb_, output int lat);
    int w;
    a = ta;
    b = tb_;
    in_valid = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_wait: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic complete_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, borrow_out} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags: {in_ready,out_valid,busy,borrow_out}=%b want 1000",
               {in_ready, out_valid, busy, borrow_out});
    end
    vectors++;
    if (diff !== 16'h0000 || x_diff !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_diff: diff=%h approx=%h want 0000", diff, x_diff);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release: {in_ready,out_valid,busy}=%b want 100",
               {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue_op(dir_a[i], dir_b[i], lat);
      $display("directed a=%h b=%h -> diff=%h bo=%b | approx diff=%h bo=%b | latency=%0d",
               dir_a[i], dir_b[i], diff, borrow_out, x_diff, x_borrow_out, lat);
      vectors++;
      if (lat !== 4 || x_out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: latency=%0d approx_valid=%b want 4 and 1",
                 i, lat, x_out_valid);
      end
      vectors++;
      if ({borrow_out, diff} !== dir_ex[i]) begin
        miscompares++;
        $display("FAIL directed_exact[%0d]: got %h want %h", i, {borrow_out, diff}, dir_ex[i]);
      end
      vectors++;
      if ({x_borrow_out, x_diff} !== dir_ax[i]) begin
        miscompares++;
        $display("FAIL directed_approx[%0d]: got %h want %h", i, {x_borrow_out, x_diff}, dir_ax[i]);
      end
      complete_op();
      vectors++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
        miscompares++;
        $display("FAIL directed_handoff[%0d]: {out_valid,in_ready,busy}=%b want 010",
                 i, {out_valid, in_ready, busy});
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] oa, ob, na, nb;
    logic [16:0] exp_e, exp_x;
    oa = 16'($urandom);
    ob = 16'($urandom);
    na = 16'($urandom);
    nb = ~ob;
    exp_e = model_exact(oa, ob);
    exp_x = model_approx(oa, ob);
    issue_op(oa, ob, lat);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a = na;
      b = nb;
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready} !== 2'b10 || {borrow_out, diff} !== exp_e
          || {x_borrow_out, x_diff} !== exp_x) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b res=%h ax=%h want 1 0 %h %h",
                 c, out_valid, in_ready, {borrow_out, diff}, {x_borrow_out, x_diff}, exp_e, exp_x);
      end
    end
    $display("backpressure a=%h b=%h -> diff=%h bo=%b held 3 cycles", oa, ob, diff, borrow_out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL backpressure_handoff: {out_valid,in_ready,busy}=%b want 010",
               {out_valid, in_ready, busy});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if ({in_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL backpressure_next_accept: {in_ready,busy}=%b want 01", {in_ready, busy});
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    $display("backpressure next a=%h b=%h -> diff=%h bo=%b latency=%0d", na, nb, diff, borrow_out, lat);
    vectors++;
    if (lat !== 4 || {borrow_out, diff} !== model_exact(na, nb)
        || {x_borrow_out, x_diff} !== model_approx(na, nb)) begin
      miscompares++;
      $display("FAIL backpressure_next_result: lat=%0d res=%h ax=%h want 4 %h %h", lat,
               {borrow_out, diff}, {x_borrow_out, x_diff}, model_exact(na, nb), model_approx(na, nb));
    end
    complete_op();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a = 16'hFFFF;
    b = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (diff !== 16'h00FE || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_partial: diff=%h busy=%b want 00fe 1", diff, busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready, busy, borrow_out} !== 4'b0100 || diff !== 16'h0000
        || x_diff !== 16'h0000) begin
      miscompares++;
      $display("FAIL midrun_reset: {ov,ir,busy,bo}=%b diff=%h ax=%h want 0100 0000 0000",
               {out_valid, in_ready, busy, borrow_out}, diff, x_diff);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    vectors++;
    if ({out_valid, x_out_valid, in_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL midrun_no_stale: {ov,ax_ov,ir}=%b want 001", {out_valid, x_out_valid, in_ready});
    end
    issue_op(16'h8000, 16'h8000, lat);
    $display("after reset a=8000 b=8000 -> diff=%h bo=%b approx diff=%h latency=%0d",
             diff, borrow_out, x_diff, lat);
    vectors++;
    if (lat !== 4 || {borrow_out, diff} !== 17'h00000 || {x_borrow_out, x_diff} !== 17'h00000) begin
      miscompares++;
      $display("FAIL midrun_reissue: lat=%0d res=%h ax=%h want 4 00000 00000",
               lat, {borrow_out, diff}, {x_borrow_out, x_diff});
    end
    complete_op();
  endtask

  task automatic test_random_sweep(input int n_ops);
    logic [16:0] exp_q[$];
    logic [16:0] axq[$];
    logic [16:0] e, x, held_e, held_x;
    logic        holding;
    int issued, completed, cyc;
    issued = 0;
    completed = 0;
    cyc = 0;
    holding = 1'b0;
    held_e = '0;
    held_x = '0;
    while (completed < n_ops && cyc < 40000) begin
      if (out_valid === 1'b1 && holding) begin
        vectors++;
        if ({borrow_out, diff} !== held_e || {x_borrow_out, x_diff} !== held_x) begin
          miscompares++;
          $display("FAIL sweep_stable: res=%h ax=%h want %h %h",
                   {borrow_out, diff}, {x_borrow_out, x_diff}, held_e, held_x);
        end
      end
      vectors++;
      if (x_out_valid !== out_valid || in_ready !== !busy) begin
        miscompares++;
        $display("FAIL sweep_flags: ov=%b ax_ov=%b ir=%b busy=%b", out_valid, x_out_valid, in_ready, busy);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (issued < n_ops) && ($urandom_range(0, 1) == 1);
      a = 16'($urandom);
      b = 16'($urandom);
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model_exact(a, b));
        axq.push_back(model_approx(a, b));
        issued++;
      end
      holding = 1'b0;
      if (out_valid === 1'b1) begin
        held_e = {borrow_out, diff};
        held_x = {x_borrow_out, x_diff};
        holding = !out_ready;
        if (out_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sweep_duplicate: result %h with nothing outstanding", {borrow_out, diff});
          end else begin
            e = exp_q.pop_front();
            x = axq.pop_front();
            $display("sweep #%0d diff=%h bo=%b (want %h) approx=%h (want %h)",
                     completed, diff, borrow_out, e, {x_borrow_out, x_diff}, x);
            if ({borrow_out, diff} !== e || {x_borrow_out, x_diff} !== x) begin
              miscompares++;
              $display("FAIL sweep_result[%0d]: res=%h ax=%h want %h %h",
                       completed, {borrow_out, diff}, {x_borrow_out, x_diff}, e, x);
            end
          end
          completed++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (completed !== n_ops || issued !== n_ops || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL sweep_count: issued=%0d completed=%0d outstanding=%0d want %0d %0d 0",
               issued, completed, exp_q.size(), n_ops, n_ops);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random_sweep(1500);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
